// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: four execution-unit requesters share three register-file
// write ports, granted round-robin with a single-cycle registered write stage.
module wb_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [3:0]              req_valid_i,
  input  logic [4*TAG_WIDTH-1:0]  req_tag_i,
  input  logic [4*DATA_WIDTH-1:0] req_data_i,
  output logic [3:0]              req_ready_o,
  output logic                    wr1_en_o,
  output logic                    wr2_en_o,
  output logic                    wr3_en_o,
  output logic [TAG_WIDTH-1:0]    wr1_tag_o,
  output logic [TAG_WIDTH-1:0]    wr2_tag_o,
  output logic [TAG_WIDTH-1:0]    wr3_tag_o,
  output logic [DATA_WIDTH-1:0]   wr1_data_o,
  output logic [DATA_WIDTH-1:0]   wr2_data_o,
  output logic [DATA_WIDTH-1:0]   wr3_data_o,
  output logic [15:0]             conflict_cnt_o
);

  logic [1:0]            rr_ptr;
  logic [1:0]            rr_next;
  logic [3:0]            grant;
  logic [2:0]            port_used;
  logic [1:0]            sel1;
  logic [1:0]            sel2;
  logic [1:0]            sel3;
  logic [1:0]            last_idx;
  logic [1:0]            scan_idx;
  logic [1:0]            fill_cnt;
  logic                  conflict;
  logic [TAG_WIDTH-1:0]  tag1;
  logic [TAG_WIDTH-1:0]  tag2;
  logic [TAG_WIDTH-1:0]  tag3;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;
  logic [DATA_WIDTH-1:0] data3;

  // Scan from the priority pointer; the n-th valid requester found takes port n+1.
  always_comb begin
    grant     = '0;
    port_used = '0;
    sel1      = '0;
    sel2      = '0;
    sel3      = '0;
    last_idx  = rr_ptr;
    scan_idx  = '0;
    fill_cnt  = '0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_ptr + 2'(i);
      if (req_valid_i[scan_idx] && fill_cnt != 2'd3) begin
        grant[scan_idx] = 1'b1;
        last_idx        = scan_idx;
        case (fill_cnt)
          2'd0: begin
            port_used[0] = 1'b1;
            sel1         = scan_idx;
          end
          2'd1: begin
            port_used[1] = 1'b1;
            sel2         = scan_idx;
          end
          default: begin
            port_used[2] = 1'b1;
            sel3         = scan_idx;
          end
        endcase
        fill_cnt = fill_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    rr_next     = (|grant) ? last_idx + 2'd1 : rr_ptr;
    conflict    = |(req_valid_i & ~grant);
    req_ready_o = (rst || flush_i) ? 4'b0000 : grant;
  end

  // Unused ports present zero tag and data so downstream never sees stale values.
  always_comb begin
    tag1  = port_used[0] ? req_tag_i[sel1*TAG_WIDTH +: TAG_WIDTH] : '0;
    tag2  = port_used[1] ? req_tag_i[sel2*TAG_WIDTH +: TAG_WIDTH] : '0;
    tag3  = port_used[2] ? req_tag_i[sel3*TAG_WIDTH +: TAG_WIDTH] : '0;
    data1 = port_used[0] ? req_data_i[sel1*DATA_WIDTH +: DATA_WIDTH] : '0;
    data2 = port_used[1] ? req_data_i[sel2*DATA_WIDTH +: DATA_WIDTH] : '0;
    data3 = port_used[2] ? req_data_i[sel3*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      conflict_cnt_o <= '0;
      wr1_en_o       <= 1'b0;
      wr2_en_o       <= 1'b0;
      wr3_en_o       <= 1'b0;
      wr1_tag_o      <= '0;
      wr2_tag_o      <= '0;
      wr3_tag_o      <= '0;
      wr1_data_o     <= '0;
      wr2_data_o     <= '0;
      wr3_data_o     <= '0;
    end else if (flush_i) begin
      wr1_en_o   <= 1'b0;
      wr2_en_o   <= 1'b0;
      wr3_en_o   <= 1'b0;
      wr1_tag_o  <= '0;
      wr2_tag_o  <= '0;
      wr3_tag_o  <= '0;
      wr1_data_o <= '0;
      wr2_data_o <= '0;
      wr3_data_o <= '0;
    end else begin
      rr_ptr     <= rr_next;
      wr1_en_o   <= port_used[0];
      wr2_en_o   <= port_used[1];
      wr3_en_o   <= port_used[2];
      wr1_tag_o  <= tag1;
      wr2_tag_o  <= tag2;
      wr3_tag_o  <= tag3;
      wr1_data_o <= data1;
      wr2_data_o <= data2;
      wr3_data_o <= data3;
      if (conflict && conflict_cnt_o != 16'hFFFF)
        conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected port writes are queued at drive
// time and compared one cycle later against the registered write ports.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int TW = 6;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [3:0]      req_valid;
  logic [4*TW-1:0] req_tag;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_ready;
  logic            wr1_en, wr2_en, wr3_en;
  logic [TW-1:0]   wr1_tag, wr2_tag, wr3_tag;
  logic [DW-1:0]   wr1_data, wr2_data, wr3_data;
  logic [15:0]     conflict_cnt;

  typedef struct packed {
    logic [2:0]  en;
    logic [5:0]  src;
    logic [15:0] cnt;
    logic [1:0]  rr;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  wb_port_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_tag_i      (req_tag),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .wr1_en_o       (wr1_en),
    .wr2_en_o       (wr2_en),
    .wr3_en_o       (wr3_en),
    .wr1_tag_o      (wr1_tag),
    .wr2_tag_o      (wr2_tag),
    .wr3_tag_o      (wr3_tag),
    .wr1_data_o     (wr1_data),
    .wr2_data_o     (wr2_data),
    .wr3_data_o     (wr3_data),
    .conflict_cnt_o (conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [TW-1:0] tag_of(input logic [1:0] k);
    return TW'(4 + int'(k));
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [1:0] k);
    return 32'hA5A5_0000 + 32'(k);
  endfunction

  task automatic checkVal(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h required %0h", name, observed, expected);
    end
  endtask

  // Drives one cycle of requests, checks the combinational grant, queues the expected writes.
  task automatic applyStimulus(input logic [3:0] v, input logic f, input logic [3:0] exp_ready,
                               input logic [2:0] exp_en, input logic [1:0] s1, input logic [1:0] s2,
                               input logic [1:0] s3, input logic [15:0] exp_cnt, input logic [1:0] exp_rr);
    exp_t e;
    req_valid = v;
    flush     = f;
    e.en  = exp_en;
    e.src = {s3, s2, s1};
    e.cnt = exp_cnt;
    e.rr  = exp_rr;
    sb.push_back(e);
    #3;
    checkVal("req_ready", 64'(req_ready), 64'(exp_ready));
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed 0 required 1");
    end else begin
      e = sb.pop_front();
      checkVal("wr1_en", 64'(wr1_en), 64'(e.en[0]));
      checkVal("wr2_en", 64'(wr2_en), 64'(e.en[1]));
      checkVal("wr3_en", 64'(wr3_en), 64'(e.en[2]));
      checkVal("wr1_tag", 64'(wr1_tag), 64'(e.en[0] ? tag_of(e.src[1:0]) : '0));
      checkVal("wr2_tag", 64'(wr2_tag), 64'(e.en[1] ? tag_of(e.src[3:2]) : '0));
      checkVal("wr3_tag", 64'(wr3_tag), 64'(e.en[2] ? tag_of(e.src[5:4]) : '0));
      checkVal("wr1_data", 64'(wr1_data), 64'(e.en[0] ? data_of(e.src[1:0]) : '0));
      checkVal("wr2_data", 64'(wr2_data), 64'(e.en[1] ? data_of(e.src[3:2]) : '0));
      checkVal("wr3_data", 64'(wr3_data), 64'(e.en[2] ? data_of(e.src[5:4]) : '0));
      checkVal("conflict_cnt", 64'(conflict_cnt), 64'(e.cnt));
      checkVal("rr_ptr", 64'(dut.rr_ptr), 64'(e.rr));
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      req_tag[k*TW +: TW]  = tag_of(2'(k));
      req_data[k*DW +: DW] = data_of(2'(k));
    end

    // Reset holds priority over pending requests.
    @(posedge clk);
    #1;
    checkVal("ready_in_reset", 64'(req_ready), 64'h0);
    sb.push_back('{en: 3'b000, src: 6'd0, cnt: 16'd0, rr: 2'd0});
    checkOutput();
    rst = 1'b0;

    applyStimulus(4'b0010, 1'b0, 4'b0010, 3'b001, 2'd1, 2'd0, 2'd0, 16'd0, 2'd2);
    checkOutput();
    applyStimulus(4'b1000, 1'b0, 4'b1000, 3'b001, 2'd3, 2'd0, 2'd0, 16'd0, 2'd0);
    checkOutput();
    applyStimulus(4'b1111, 1'b0, 4'b0111, 3'b111, 2'd0, 2'd1, 2'd2, 16'd1, 2'd3);
    checkOutput();
    applyStimulus(4'b1111, 1'b0, 4'b1011, 3'b111, 2'd3, 2'd0, 2'd1, 16'd2, 2'd2);
    checkOutput();
    applyStimulus(4'b1001, 1'b0, 4'b1001, 3'b011, 2'd3, 2'd0, 2'd0, 16'd2, 2'd1);
    checkOutput();
    applyStimulus(4'b0000, 1'b0, 4'b0000, 3'b000, 2'd0, 2'd0, 2'd0, 16'd2, 2'd1);
    checkOutput();
    applyStimulus(4'b0101, 1'b0, 4'b0101, 3'b011, 2'd2, 2'd0, 2'd0, 16'd2, 2'd1);
    checkOutput();
    applyStimulus(4'b1111, 1'b1, 4'b0000, 3'b000, 2'd0, 2'd0, 2'd0, 16'd2, 2'd1);
    checkOutput();
    applyStimulus(4'b1111, 1'b0, 4'b1110, 3'b111, 2'd1, 2'd2, 2'd3, 16'd3, 2'd0);
    checkOutput();
    applyStimulus(4'b0001, 1'b0, 4'b0001, 3'b001, 2'd0, 2'd0, 2'd0, 16'd3, 2'd1);
    checkOutput();

    // Long full-contention run drives the conflict counter into saturation.
    req_valid = 4'b1111;
    flush     = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    checkVal("conflict_saturated", 64'(conflict_cnt), 64'hFFFF);
    @(posedge clk);
    #1;
    checkVal("conflict_held", 64'(conflict_cnt), 64'hFFFF);

    rst = 1'b1;
    #3;
    checkVal("ready_in_reset2", 64'(req_ready), 64'h0);
    sb.push_back('{en: 3'b000, src: 6'd0, cnt: 16'd0, rr: 2'd0});
    checkOutput();
    rst = 1'b0;

    applyStimulus(4'b1111, 1'b0, 4'b0111, 3'b111, 2'd0, 2'd1, 2'd2, 16'd1, 2'd3);
    checkOutput();

    checkVal("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
